// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared types and constants for the instruction-fetch stage.
package mips_fetch_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} fetch_state_t;

    localparam logic [1:0] PC_SRC_BRANCH = 2'b00;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
    localparam logic [1:0] PC_SRC_JR     = 2'b10;
    localparam logic [1:0] PC_SRC_HOLD   = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: selects the next PC for branch, jump, jr or hold.
module pc_next_mux
    import mips_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] ext_imm,
    input  logic [31:0] jr_target,
    input  logic [1:0]  pc_src,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc_src == PC_SRC_BRANCH ? pc + ext_imm :
                  pc_src == PC_SRC_JUMP   ? {pc[31:28], ext_imm[27:0]} :
                  pc_src == PC_SRC_JR     ? jr_target : pc;
    end

endmodule

// File: rtl/ir_fetch_unit.sv
// ir_fetch_unit: owns PC and IR, fetches an instruction word from memory with MOC handshake and timeout.
module ir_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [7:0]  MAX_WAIT = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic        pc_load,
    input  logic [1:0]  pc_src,
    input  logic [31:0] ext_imm,
    input  logic [31:0] jr_target,
    input  logic [31:0] mem_data,
    input  logic        mem_moc,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    output logic [31:0] ir,
    output logic [31:0] pc,
    output logic        fetch_done,
    output logic        busy,
    output logic        fetch_err
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d, ir_q, ir_d, addr_q, addr_d, next_pc;
    logic [7:0]   cnt_q, cnt_d;
    logic         err_q, err_d, rd_q, done_q;

    pc_next_mux u_mux (
        .pc        (pc_q),
        .ext_imm   (ext_imm),
        .jr_target (jr_target),
        .pc_src    (pc_src),
        .next_pc   (next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                pc_d = pc_load ? next_pc : pc_q;
                // alignment check and fetch address both use the just-loaded PC
                if (fetch_start) begin
                    state_d = pc_d[1:0] != 2'b00 ? ERR : WAIT;
                    err_d   = pc_d[1:0] != 2'b00;
                    addr_d  = pc_d;
                    cnt_d   = 8'd0;
                end
            end
            WAIT: begin
                if (mem_moc) begin
                    ir_d    = mem_data;
                    pc_d    = pc_q + 32'd4;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = cnt_d == MAX_WAIT ? ERR : WAIT;
                    err_d   = cnt_d == MAX_WAIT;
                end
            end
            DONE: begin
                pc_d    = pc_load ? next_pc : pc_q;
                state_d = IDLE;
            end
            default: state_d = ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            addr_q  <= RESET_PC;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rd_q    <= state_d == WAIT;
            done_q  <= state_d == DONE;
        end
    end

    assign mem_rd     = rd_q;
    assign mem_addr   = addr_q;
    assign ir         = ir_q;
    assign pc         = pc_q;
    assign fetch_done = done_q;
    assign busy       = state_q != IDLE;
    assign fetch_err  = err_q;

endmodule
